// File: rtl/reg_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
package reg_pkg;

  localparam int REG_W = 30;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_stage.sv
// One valid/data slot of the elastic pipeline; ready is combinational from downstream.
module register_stage
  import reg_pkg::*;
#(
  parameter int               WIDTH     = REG_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             i_val,
  output logic             i_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_val,
  input  logic             o_rdy,
  output logic [WIDTH-1:0] o_data
);

  logic             val_q, val_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load;

  assign i_rdy  = !val_q || o_rdy;
  assign load   = i_val && i_rdy;
  assign o_val  = val_q;
  assign o_data = data_q;

  // Data only moves on a load, so a stalled output word stays stable.
  always_comb begin
    val_d  = val_q;
    data_d = data_q;
    if (flush) begin
      val_d  = 1'b0;
      data_d = RESET_VAL;
    end else if (load) begin
      val_d  = 1'b1;
      data_d = i_data;
    end else if (o_rdy) begin
      val_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      val_q  <= 1'b0;
      data_q <= RESET_VAL;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/register_pipe.sv
// DEPTH-stage elastic register pipeline with synchronous flush and occupancy count.
// in_rdy depends combinationally on out_rdy through the whole ready chain.
module register_pipe
  import reg_pkg::*;
#(
  parameter int               WIDTH     = REG_W,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("register_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH:0]   r;
  logic [WIDTH-1:0] d [DEPTH];

  assign r[DEPTH] = out_rdy;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             s_val;
    logic [WIDTH-1:0] s_data;

    if (i == 0) begin : g_head
      assign s_val  = in_val && !flush;
      assign s_data = in_data;
    end else begin : g_body
      assign s_val  = v[i-1];
      assign s_data = d[i-1];
    end

    register_stage #(
      .WIDTH    (WIDTH),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .i_val (s_val),
      .i_rdy (r[i]),
      .i_data(s_data),
      .o_val (v[i]),
      .o_rdy (r[i+1]),
      .o_data(d[i])
    );
  end

  assign in_rdy   = r[0] && !flush;
  assign out_val  = v[DEPTH-1];
  assign out_data = d[DEPTH-1];

  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign push  = in_val && in_rdy;
  assign pop   = out_val && out_rdy;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
